// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key schedule: expands one round per clock into a round-key table,
// exposes the final round key, and streams the table forward or reverse over valid/ready.
module aes_key_schedule_seq #(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [127:0]       key_in,
    output logic               busy,
    output logic               table_valid,
    output logic [127:0]       key_final,
    input  logic               strm_req,
    input  logic               strm_dir,
    output logic               strm_valid,
    input  logic               strm_ready,
    output logic [127:0]       strm_key,
    output logic [IDX_W-1:0]   strm_idx,
    output logic               strm_last
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        LOADED = 2'd2,
        STREAM = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One KeyGeneration round: RotWord, SubWord, Rcon, then the word cascade.
    function automatic logic [127:0] key_round(input logic [127:0] k, input logic [3:0] rc);
        logic [31:0] temp, w0, w1, w2, w3;
        temp = sub_word({k[23:0], k[31:24]}) ^ {rcon(rc), 24'h000000};
        w0   = k[127:96] ^ temp;
        w1   = k[95:64]  ^ w0;
        w2   = k[63:32]  ^ w1;
        w3   = k[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                dir_q, dir_d;
    logic [127:0]        slot_q [NUM_ROUNDS+1];

    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [127:0]        wr_data;
    logic [IDX_W-1:0]    prev_idx;
    logic [127:0]        round_key;
    logic [IDX_W-1:0]    end_idx;

    assign prev_idx  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    assign round_key = key_round(slot_q[prev_idx], 4'(prev_idx));

    assign busy        = (state_q == EXPAND);
    assign table_valid = (state_q == LOADED) || (state_q == STREAM);
    assign strm_valid  = (state_q == STREAM);
    assign key_final   = slot_q[NUM_ROUNDS];
    assign end_idx     = dir_q ? '0 : LAST_IDX;
    assign strm_idx    = idx_q;
    assign strm_key    = strm_valid ? slot_q[idx_q] : '0;
    assign strm_last   = strm_valid && (idx_q == end_idx);

    // NOTE: every signal assigned here gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_data = key_in;
        case (state_q)
            IDLE, LOADED: begin
                if (start) begin
                    wr_en   = 1'b1;
                    cnt_d   = IDX_W'(1);
                    state_d = EXPAND;
                end else if (state_q == LOADED && strm_req) begin
                    dir_d   = strm_dir;
                    idx_d   = strm_dir ? LAST_IDX : '0;
                    state_d = STREAM;
                end
            end
            EXPAND: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_data = round_key;
                if (cnt_q == LAST_IDX) state_d = LOADED;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            STREAM: begin
                if (strm_ready) begin
                    if (strm_last)  state_d = LOADED;
                    else if (dir_q) idx_d   = idx_q - 1'b1;
                    else            idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the key table is reset along with the control state so a reset leaves no stale keys visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            if (wr_en) slot_q[wr_idx] <= wr_data;
        end
    end

endmodule
